// File: rtl/ysyx_23060201_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ysyx_23060201_pkg                                               |
// | Brief  : Shared constants for the multi-cycle execute unit: RV opcodes,  |
// |          funct3/funct7 codes, ALU control codes and the FSM encoding.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package ysyx_23060201_pkg;

  // Major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load funct3 (stores use the low two bits for size)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // ALU funct3 values that honour the alternate funct7 bit
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  // ALU control: {alternate bit, funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_EXEC     = 3'd1;
  localparam state_t S_MEM_REQ  = 3'd2;
  localparam state_t S_MEM_WAIT = 3'd3;
  localparam state_t S_DONE     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060201_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ysyx_23060201_alu                                               |
// | Brief  : Combinational integer ALU.                                      |
// |   ctl  in  4          operation select ({alt, funct3})                   |
// |   a    in  DATA_WIDTH operand A                                          |
// |   b    in  DATA_WIDTH operand B (low log2(DATA_WIDTH) bits = shamt)      |
// |   y    out DATA_WIDTH result                                             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module ysyx_23060201_alu
  import ysyx_23060201_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            ctl,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    y = a + b;
    case (ctl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(DATA_WIDTH-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = DATA_WIDTH'($signed(a) >>> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060201_exu_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ysyx_23060201_exu_mc                                            |
// | Brief  : Multi-cycle execute unit. Accepts one decoded instruction,      |
// |          executes it, performs at most one memory access and presents    |
// |          the writeback / redirect result until downstream accepts it.    |
// | Ports  : clk/rst          clock, synchronous active-high reset           |
// |          in_*             decoded instruction handshake + operands       |
// |          mem_req_*        memory request channel (valid/ready)           |
// |          mem_resp_*       memory response (load data / store ack)        |
// |          out_*, gpr_*,    result handshake, register writeback and       |
// |          jump_en, dnpc    next-pc redirect                               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module ysyx_23060201_exu_mc
  import ysyx_23060201_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [6:0]                op,
  input  logic [4:0]                rd,
  input  logic [2:0]                func3,
  input  logic [6:0]                func7,
  input  logic [DATA_WIDTH-1:0]     rs1,
  input  logic [DATA_WIDTH-1:0]     rs2,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_req_wmask,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      gpr_wen,
  output logic [4:0]                gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      jump_en,
  output logic [MEM_ADDR_WIDTH-1:0] dnpc
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  state_t state_q, state_d;

  // Latched instruction
  logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [6:0]                op_q, op_d, func7_q, func7_d;
  logic [4:0]                rd_q, rd_d;
  logic [2:0]                func3_q, func3_d;

  // Results
  logic [DATA_WIDTH-1:0]     result_q, result_d, wdata_q, wdata_d;
  logic [MEM_ADDR_WIDTH-1:0] dnpc_q, dnpc_d, addr_q, addr_d;
  logic [STRB_W-1:0]         wmask_q, wmask_d;
  logic                      wen_q, wen_d, jump_q, jump_d, mem_wen_q, mem_wen_d;

  // ---------------- execute datapath ----------------
  logic [3:0]                alu_ctl;
  logic [DATA_WIDTH-1:0]     alu_b, alu_y;
  logic [MEM_ADDR_WIDTH-1:0] pc_imm, pc_4, mem_addr;
  logic [OFF_W-1:0]          st_off, ld_off;
  logic [STRB_W-1:0]         st_base;
  logic [DATA_WIDTH-1:0]     ld_shift, ld_data, ex_result;
  logic                      br_taken, ex_wen, ex_jump, is_mem;
  logic [MEM_ADDR_WIDTH-1:0] ex_dnpc;
  logic                      unused_func7;

  // Only the alternate bit of funct7 affects execution.
  assign unused_func7 = ^{func7_q[6], func7_q[4:0]};

  always_comb begin
    alu_b   = imm_q;
    alu_ctl = ALU_ADD;
    if (op_q == OP_REG) begin
      alu_b   = rs2_q;
      alu_ctl = {((func3_q == F3_ADD) || (func3_q == F3_SR)) && func7_q[5], func3_q};
    end else if (op_q == OP_IMM) begin
      // addi has no subtract form; only shifts-right read the alt bit.
      alu_ctl = {(func3_q == F3_SR) && func7_q[5], func3_q};
    end
  end

  ysyx_23060201_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .ctl (alu_ctl),
    .a   (rs1_q),
    .b   (alu_b),
    .y   (alu_y)
  );

  assign pc_imm   = pc_q + MEM_ADDR_WIDTH'($signed(imm_q));
  assign pc_4     = pc_q + MEM_ADDR_WIDTH'(4);
  assign mem_addr = MEM_ADDR_WIDTH'($signed(alu_y));
  assign is_mem   = (op_q == OP_LOAD) || (op_q == OP_STORE);

  always_comb begin
    case (func3_q)
      F3_BEQ:  br_taken = (rs1_q == rs2_q);
      F3_BNE:  br_taken = (rs1_q != rs2_q);
      F3_BLT:  br_taken = ($signed(rs1_q) <  $signed(rs2_q));
      F3_BGE:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
      F3_BLTU: br_taken = (rs1_q <  rs2_q);
      F3_BGEU: br_taken = (rs1_q >= rs2_q);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    ex_result = alu_y;
    ex_wen    = (rd_q != 5'd0);
    ex_jump   = 1'b0;
    ex_dnpc   = pc_4;
    case (op_q)
      OP_REG, OP_IMM: ;
      OP_LUI:   ex_result = imm_q;
      OP_AUIPC: ex_result = DATA_WIDTH'(pc_imm);
      OP_JAL: begin
        ex_result = DATA_WIDTH'(pc_4);
        ex_jump   = 1'b1;
        ex_dnpc   = pc_imm;
      end
      OP_JALR: begin
        ex_result = DATA_WIDTH'(pc_4);
        ex_jump   = 1'b1;
        ex_dnpc   = mem_addr & ~MEM_ADDR_WIDTH'(1);
      end
      OP_BRANCH: begin
        ex_wen  = 1'b0;
        ex_jump = br_taken;
        ex_dnpc = br_taken ? pc_imm : pc_4;
      end
      OP_LOAD:  ex_result = '0;
      OP_STORE: ex_wen = 1'b0;
      default: begin
        ex_result = '0;
        ex_wen    = 1'b0;
      end
    endcase
  end

  // Store lane alignment; lanes shifted past the word edge are dropped.
  assign st_off = mem_addr[OFF_W-1:0];
  always_comb begin
    case (func3_q[1:0])
      2'b00:   st_base = STRB_W'(1);
      2'b01:   st_base = STRB_W'(3);
      2'b10:   st_base = STRB_W'(15);
      default: st_base = {STRB_W{1'b1}};
    endcase
  end

  // Load lane extraction from the raw aligned word.
  assign ld_off   = addr_q[OFF_W-1:0];
  assign ld_shift = mem_resp_rdata >> {ld_off, 3'b000};
  always_comb begin
    case (func3_q)
      F3_LB:   ld_data = DATA_WIDTH'($signed(ld_shift[7:0]));
      F3_LH:   ld_data = DATA_WIDTH'($signed(ld_shift[15:0]));
      F3_LW:   ld_data = DATA_WIDTH'($signed(ld_shift[31:0]));
      F3_LBU:  ld_data = DATA_WIDTH'(ld_shift[7:0]);
      F3_LHU:  ld_data = DATA_WIDTH'(ld_shift[15:0]);
      F3_LWU:  ld_data = DATA_WIDTH'(ld_shift[31:0]);
      F3_LD:   ld_data = ld_shift;
      default: ld_data = ld_shift;
    endcase
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (in_valid)       state_d = S_EXEC;
      S_EXEC:     state_d = is_mem ? S_MEM_REQ : S_DONE;
      S_MEM_REQ:  if (mem_req_ready)  state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (mem_resp_valid) state_d = S_DONE;
      S_DONE:     if (out_ready)      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    pc_d      = pc_q;
    imm_d     = imm_q;
    op_d      = op_q;
    rd_d      = rd_q;
    func3_d   = func3_q;
    func7_d   = func7_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    result_d  = result_q;
    wen_d     = wen_q;
    jump_d    = jump_q;
    dnpc_d    = dnpc_q;
    addr_d    = addr_q;
    mem_wen_d = mem_wen_q;
    wmask_d   = wmask_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        pc_d    = pc;
        imm_d   = imm;
        op_d    = op;
        rd_d    = rd;
        func3_d = func3;
        func7_d = func7;
        rs1_d   = rs1;
        rs2_d   = rs2;
      end
      S_EXEC: begin
        result_d  = ex_result;
        wen_d     = ex_wen;
        jump_d    = ex_jump;
        dnpc_d    = ex_dnpc;
        addr_d    = mem_addr;
        mem_wen_d = (op_q == OP_STORE);
        wmask_d   = (op_q == OP_STORE) ? (st_base << st_off) : '0;
        wdata_d   = (op_q == OP_STORE) ? (rs2_q << {st_off, 3'b000}) : '0;
      end
      S_MEM_WAIT: if (mem_resp_valid && !mem_wen_q) result_d = ld_data;
      default: ;
    endcase
  end

  // ---------------- state / data registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      imm_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      func3_q   <= '0;
      func7_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      result_q  <= '0;
      wen_q     <= 1'b0;
      jump_q    <= 1'b0;
      dnpc_q    <= '0;
      addr_q    <= '0;
      mem_wen_q <= 1'b0;
      wmask_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      func3_q   <= func3_d;
      func7_q   <= func7_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      result_q  <= result_d;
      wen_q     <= wen_d;
      jump_q    <= jump_d;
      dnpc_q    <= dnpc_d;
      addr_q    <= addr_d;
      mem_wen_q <= mem_wen_d;
      wmask_q   <= wmask_d;
      wdata_q   <= wdata_d;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready      = (state_q == S_IDLE);
    out_valid     = (state_q == S_DONE);
    mem_req_valid = (state_q == S_MEM_REQ);
    // Strobes qualified by DONE so a stale result never writes back.
    gpr_wen       = (state_q == S_DONE) && wen_q;
    jump_en       = (state_q == S_DONE) && jump_q;
  end

  assign mem_req_wen   = mem_wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wmask = wmask_q;
  assign mem_req_wdata = wdata_q;
  assign gpr_waddr     = rd_q;
  assign gpr_wdata     = result_q;
  assign dnpc          = dnpc_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060201_exu_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_ysyx_23060201_exu_mc                                         |
// | Brief  : Directed self-checking bench for ysyx_23060201_exu_mc.          |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_ysyx_23060201_exu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0;
  logic [6:0]  op = '0, func7 = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  func3 = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        out_valid, out_ready = 1'b0, gpr_wen, jump_en;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata, dnpc;

  ysyx_23060201_exu_mc #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .op(op), .rd(rd), .func3(func3), .func7(func7),
    .rs1(rs1), .rs2(rs2),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .jump_en(jump_en), .dnpc(dnpc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] pc, rs1, rs2, imm, wdata;
    logic        wen, jump;
    logic [31:0] dnpc;
    int          hold;
  } alu_vec_t;

  alu_vec_t vecs [24];

  // Drive one instruction for one cycle (called at a negedge); inputs are
  // scrambled right after so the DUT must be using its latched copy.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] i);
    check("in_ready idle", in_ready, 1);
    op = o; func3 = f3; func7 = f7; rd = r; pc = p; rs1 = a; rs2 = b; imm = i;
    in_valid = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    op = 7'h7F; func3 = 3'h7; func7 = 7'h7F; rd = 5'h1F;
    pc = 32'hDEAD_BEEF; rs1 = 32'h5555_5555; rs2 = 32'hAAAA_AAAA; imm = 32'h1234_5678;
  endtask

  task automatic wait_out();
    int k = 0;
    while (out_valid !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("out_valid", out_valid, 1);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid after retire", out_valid, 0);
    check("in_ready after retire", in_ready, 1);
  endtask

  task automatic do_alu(input alu_vec_t v);
    issue(v.op, v.f3, v.f7, v.rd, v.pc, v.rs1, v.rs2, v.imm);
    check("in_ready busy", in_ready, 0);
    wait_out();
    check("alu latency", cyc - t_acc, 2);
    check("gpr_wen", gpr_wen, v.wen);
    check("gpr_waddr", gpr_waddr, v.rd);
    if (v.wen) check("gpr_wdata", gpr_wdata, v.wdata);
    check("jump_en", jump_en, v.jump);
    check("dnpc", dnpc, v.dnpc);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("hold out_valid", out_valid, 1);
      check("hold in_ready", in_ready, 0);
      check("hold gpr_wdata", gpr_wdata, v.wdata);
      check("hold gpr_wen", gpr_wen, v.wen);
    end
    retire();
  endtask

  // Memory op: request held for req_wait cycles, response in the first
  // MEM_WAIT cycle, so accept->out_valid = 4 + req_wait cycles.
  task automatic do_mem(input string tag, input logic [6:0] o, input logic [2:0] f3,
                        input logic [4:0] r, input logic [31:0] a, input logic [31:0] i,
                        input logic [31:0] b, input int req_wait, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic [3:0] e_mask,
                        input logic [31:0] e_wdata, input logic [31:0] e_res);
    int   k = 0;
    logic st;
    st = (o == 7'b0100011);
    issue(o, f3, 7'h00, r, 32'h0000_1000, a, b, i);
    while (mem_req_valid !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    check({tag, " req_valid"}, mem_req_valid, 1);
    check({tag, " addr"}, mem_req_addr, e_addr);
    check({tag, " wen"}, mem_req_wen, st);
    if (st) begin
      check({tag, " wmask"}, mem_req_wmask, e_mask);
      check({tag, " wdata"}, mem_req_wdata, e_wdata);
    end
    for (int w = 0; w < req_wait; w++) begin
      @(negedge clk);
      check({tag, " stall valid"}, mem_req_valid, 1);
      check({tag, " stall addr"}, mem_req_addr, e_addr);
      check({tag, " stall wmask"}, mem_req_wmask, st ? e_mask : 4'h0);
      check({tag, " stall wdata"}, mem_req_wdata, st ? e_wdata : 32'h0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check({tag, " req dropped"}, mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " latency"}, cyc - t_acc, 4 + req_wait);
    check({tag, " gpr_wen"}, gpr_wen, !st && (r != 5'd0));
    if (!st) check({tag, " gpr_wdata"}, gpr_wdata, e_res);
    check({tag, " jump_en"}, jump_en, 0);
    check({tag, " dnpc"}, dnpc, 32'h0000_1004);
    retire();
  endtask

  initial begin
    //            op      f3    f7     rd  pc            rs1           rs2           imm           wdata         wen   jump  dnpc          hold
    vecs[0]  = '{7'h13, 3'd0, 7'h00, 5,  32'h0000_1000, 32'h0000_0010, 32'h0,        32'hFFFF_FFFF, 32'h0000_000F, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[1]  = '{7'h33, 3'd0, 7'h20, 7,  32'h0000_1000, 32'h0000_000A, 32'h3,        32'h0,         32'h0000_0007, 1'b1, 1'b0, 32'h0000_1004, 5};
    vecs[2]  = '{7'h33, 3'd5, 7'h20, 1,  32'h0000_1000, 32'hF000_0000, 32'h4,        32'h0,         32'hFF00_0000, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[3]  = '{7'h13, 3'd5, 7'h20, 2,  32'h0000_1000, 32'h8000_0000, 32'h0,        32'h0000_0404, 32'hF800_0000, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[4]  = '{7'h33, 3'd5, 7'h00, 2,  32'h0000_1000, 32'hF000_0000, 32'h4,        32'h0,         32'h0F00_0000, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[5]  = '{7'h33, 3'd3, 7'h00, 3,  32'h0000_1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,        32'h0000_0001, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[6]  = '{7'h33, 3'd2, 7'h00, 3,  32'h0000_1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,        32'h0000_0000, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[7]  = '{7'h33, 3'd1, 7'h00, 4,  32'h0000_1000, 32'h0000_0001, 32'h25,       32'h0,         32'h0000_0020, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[8]  = '{7'h33, 3'd4, 7'h00, 4,  32'h0000_1000, 32'h0000_F0F0, 32'hFF00,     32'h0,         32'h0000_0FF0, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[9]  = '{7'h33, 3'd6, 7'h00, 4,  32'h0000_1000, 32'h0000_F0F0, 32'hFF00,     32'h0,         32'h0000_FFF0, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[10] = '{7'h33, 3'd7, 7'h00, 4,  32'h0000_1000, 32'h0000_F0F0, 32'hFF00,     32'h0,         32'h0000_F000, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[11] = '{7'h13, 3'd2, 7'h00, 6,  32'h0000_1000, 32'hFFFF_FFFF, 32'h0,        32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[12] = '{7'h37, 3'd0, 7'h00, 2,  32'h0000_1000, 32'h0,         32'h0,        32'h1234_5000, 32'h1234_5000, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[13] = '{7'h17, 3'd0, 7'h00, 2,  32'h0000_1000, 32'h0,         32'h0,        32'h0000_2000, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_1004, 0};
    vecs[14] = '{7'h6F, 3'd0, 7'h00, 1,  32'h0000_1000, 32'h0,         32'h0,        32'h0000_0100, 32'h0000_1004, 1'b1, 1'b1, 32'h0000_1100, 0};
    vecs[15] = '{7'h67, 3'd0, 7'h00, 1,  32'h0000_1000, 32'h0000_2003, 32'h0,        32'h0000_0010, 32'h0000_1004, 1'b1, 1'b1, 32'h0000_2012, 0};
    vecs[16] = '{7'h63, 3'd1, 7'h00, 0,  32'h8000_0000, 32'h0000_0001, 32'h2,        32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h8000_0010, 0};
    vecs[17] = '{7'h63, 3'd1, 7'h00, 0,  32'h8000_0000, 32'h0000_0002, 32'h2,        32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'h8000_0004, 0};
    vecs[18] = '{7'h63, 3'd6, 7'h00, 0,  32'h0000_1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h0,        1'b0, 1'b1, 32'h0000_0FF0, 0};
    vecs[19] = '{7'h63, 3'd5, 7'h00, 0,  32'h0000_1000, 32'hFFFF_FFFF, 32'h1,        32'h0000_0008, 32'h0,         1'b0, 1'b0, 32'h0000_1004, 0};
    vecs[20] = '{7'h7F, 3'd0, 7'h00, 3,  32'h0000_1000, 32'h0000_0005, 32'h5,        32'h0000_0005, 32'h0,         1'b0, 1'b0, 32'h0000_1004, 0};
    vecs[21] = '{7'h13, 3'd0, 7'h00, 0,  32'h0000_1000, 32'h0000_0005, 32'h0,        32'h0000_0001, 32'h0,         1'b0, 1'b0, 32'h0000_1004, 0};
    vecs[22] = '{7'h13, 3'd0, 7'h00, 8,  32'hFFFF_FFFC, 32'h0000_0001, 32'h0,        32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0000, 0};
    vecs[23] = '{7'h33, 3'd0, 7'h00, 9,  32'h0000_1000, 32'hFFFF_FFFF, 32'h2,        32'h0,         32'h0000_0001, 1'b1, 1'b0, 32'h0000_1004, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst mem_req_valid", mem_req_valid, 0);
    check("rst gpr_wen", gpr_wen, 0);
    check("rst jump_en", jump_en, 0);
    check("rst gpr_wdata", gpr_wdata, 0);
    check("rst gpr_waddr", gpr_waddr, 0);
    check("rst dnpc", dnpc, 0);
    check("rst mem_req_addr", mem_req_addr, 0);
    check("rst mem_req_wmask", mem_req_wmask, 0);
    check("rst mem_req_wdata", mem_req_wdata, 0);
    check("rst mem_req_wen", mem_req_wen, 0);

    foreach (vecs[n]) do_alu(vecs[n]);

    //      tag    op      f3    rd  rs1            imm            rs2            wait rdata          addr           mask  wdata          result
    do_mem("lb",  7'h03, 3'd0, 6,  32'h8000_0001, 32'h0,         32'h0,         0,   32'h0000_8000, 32'h8000_0001, 4'h0, 32'h0,         32'hFFFF_FF80);
    do_mem("sh",  7'h23, 3'd1, 0,  32'h0000_0100, 32'h2,         32'h0000_ABCD, 3,   32'h0,         32'h0000_0102, 4'hC, 32'hABCD_0000, 32'h0);
    do_mem("sb",  7'h23, 3'd0, 0,  32'h0000_0200, 32'h3,         32'h1122_3344, 0,   32'h0,         32'h0000_0203, 4'h8, 32'h4400_0000, 32'h0);
    do_mem("sw",  7'h23, 3'd2, 0,  32'h0000_0400, 32'h0,         32'hCAFE_BABE, 1,   32'h0,         32'h0000_0400, 4'hF, 32'hCAFE_BABE, 32'h0);
    do_mem("swm", 7'h23, 3'd2, 0,  32'h0000_0402, 32'h0,         32'h1122_3344, 0,   32'h0,         32'h0000_0402, 4'hC, 32'h3344_0000, 32'h0);
    do_mem("lw",  7'h03, 3'd2, 10, 32'h0000_0300, 32'h0,         32'h0,         0,   32'h89AB_CDEF, 32'h0000_0300, 4'h0, 32'h0,         32'h89AB_CDEF);
    do_mem("lbu", 7'h03, 3'd4, 11, 32'h0000_0203, 32'h0,         32'h0,         0,   32'h8011_2233, 32'h0000_0203, 4'h0, 32'h0,         32'h0000_0080);
    do_mem("lh",  7'h03, 3'd1, 12, 32'h0000_0200, 32'h2,         32'h0,         2,   32'h8001_0000, 32'h0000_0202, 4'h0, 32'h0,         32'hFFFF_8001);
    do_mem("lhu", 7'h03, 3'd5, 12, 32'h0000_0200, 32'h2,         32'h0,         0,   32'hBEEF_1234, 32'h0000_0202, 4'h0, 32'h0,         32'h0000_BEEF);

    // Reset while waiting for a load response; the late response is dropped.
    issue(7'h03, 3'd2, 7'h00, 13, 32'h0000_1000, 32'h0000_0300, 32'h0, 32'h0);
    @(negedge clk);
    check("abort req_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("late resp out_valid", out_valid, 0);
      check("late resp in_ready", in_ready, 1);
      check("late resp gpr_wen", gpr_wen, 0);
      @(negedge clk);
    end
    do_alu(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
